// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE loop-nest controller.
package pe_ctrl_pkg;

    localparam int unsigned IDX_WIDTH_DEF  = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } loop_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] base;
        logic [IDX_WIDTH_DEF-1:0]  inner_cnt;
        logic [IDX_WIDTH_DEF-1:0]  outer_cnt;
        logic [ADDR_WIDTH_DEF-1:0] inner_stride;
        logic [ADDR_WIDTH_DEF-1:0] outer_stride;
    } loop_cfg_t;

endpackage

// File: rtl/loop_nest_ctrl_level_cnt.sv
// One loop level: index counter with clear, enable and terminal-count flag.
module loop_level_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] cnt_i,
    output logic [W-1:0] idx_o,
    output logic         tc_o
);

    logic [W-1:0] idx_q, idx_d;

    // cnt_i is never 0 while enabled, so cnt_i-1 cannot underflow here
    assign tc_o = (idx_q == (cnt_i - W'(1)));

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (en_i) begin
            idx_d = tc_o ? '0 : idx_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/loop_nest_ctrl.sv
// Two-level loop sequencer streaming address/index beats to the operand buffer.
// Optional abort input and sticky aborted flag under LOOP_NEST_CTRL_ABORT_EN.
//
// state | meaning
// IDLE  | accepting config, waiting for start
// RUN   | presenting beats, advancing on each accept
// DONE  | one-cycle completion pulse
module loop_nest_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned IDX_WIDTH  = IDX_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [IDX_WIDTH-1:0]  cfg_inner_cnt,
    input  logic [IDX_WIDTH-1:0]  cfg_outer_cnt,
    input  logic [ADDR_WIDTH-1:0] cfg_inner_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_outer_stride,
    input  logic                  start,
`ifdef LOOP_NEST_CTRL_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [IDX_WIDTH-1:0]  out_inner_idx,
    output logic [IDX_WIDTH-1:0]  out_outer_idx,
    output logic                  out_last_inner,
    output logic                  out_last
);

    loop_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q, istr_q, ostr_q;
    logic [IDX_WIDTH-1:0]  icnt_q, ocnt_q;
    logic [ADDR_WIDTH-1:0] row_q, row_d, addr_q, addr_d;

    logic                  in_idle, in_run;
    logic                  cfg_hs, start_go, empty, accept, abort_hit;
    logic                  inner_tc, outer_tc;
    logic [IDX_WIDTH-1:0]  inner_idx, outer_idx;
    logic [ADDR_WIDTH-1:0] eff_base;
    logic [IDX_WIDTH-1:0]  eff_icnt, eff_ocnt;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_run   = (state_q == ST_RUN);
    assign cfg_hs   = cfg_valid && in_idle;
    assign start_go = start && in_idle;
    assign accept   = in_run && out_ready;

    // a config handshake in the start cycle takes effect immediately
    assign eff_base = cfg_hs ? cfg_base      : base_q;
    assign eff_icnt = cfg_hs ? cfg_inner_cnt : icnt_q;
    assign eff_ocnt = cfg_hs ? cfg_outer_cnt : ocnt_q;
    assign empty    = (eff_icnt == '0) || (eff_ocnt == '0);

`ifdef LOOP_NEST_CTRL_ABORT_EN
    logic aborted_q;
    assign abort_hit = in_run && abort;
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else if (start_go) begin
            aborted_q <= 1'b0;
        end else if (abort_hit) begin
            aborted_q <= 1'b1;
        end
    end
    assign aborted = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_go) state_d = empty ? ST_DONE : ST_RUN;
            ST_RUN:  if ((accept && inner_tc && outer_tc) || abort_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            icnt_q  <= '0;
            ocnt_q  <= '0;
            istr_q  <= '0;
            ostr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_hs) begin
                base_q <= cfg_base;
                icnt_q <= cfg_inner_cnt;
                ocnt_q <= cfg_outer_cnt;
                istr_q <= cfg_inner_stride;
                ostr_q <= cfg_outer_stride;
            end
        end
    end

    loop_level_cnt #(.W(IDX_WIDTH)) u_inner (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!in_run),
        .en_i  (accept),
        .cnt_i (icnt_q),
        .idx_o (inner_idx),
        .tc_o  (inner_tc)
    );

    loop_level_cnt #(.W(IDX_WIDTH)) u_outer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!in_run),
        .en_i  (accept && inner_tc),
        .cnt_i (ocnt_q),
        .idx_o (outer_idx),
        .tc_o  (outer_tc)
    );

    always_comb begin
        row_d  = row_q;
        addr_d = addr_q;
        if (start_go) begin
            row_d  = eff_base;
            addr_d = eff_base;
        end else if (state_q == ST_DONE) begin
            row_d  = '0;
            addr_d = '0;
        end else if (accept) begin
            if (inner_tc) begin
                row_d  = row_q + ostr_q;
                addr_d = row_d;
            end else begin
                addr_d = addr_q + istr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign cfg_ready      = in_idle;
    assign busy           = !in_idle;
    assign done           = (state_q == ST_DONE);
    assign out_valid      = in_run;
    assign out_addr       = in_run ? addr_q : '0;
    assign out_inner_idx  = in_run ? inner_idx : '0;
    assign out_outer_idx  = in_run ? outer_idx : '0;
    assign out_last_inner = in_run && inner_tc;
    assign out_last       = in_run && inner_tc && outer_tc;

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Directed and randomized checks of loop_nest_ctrl against a nested-loop reference model.
module tb_loop_nest_ctrl;
    import pe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready, start, busy, done;
    logic [15:0] cfg_base, cfg_inner_stride, cfg_outer_stride;
    logic [7:0]  cfg_inner_cnt, cfg_outer_cnt;
    logic        out_valid, out_ready, out_last_inner, out_last;
    logic [15:0] out_addr;
    logic [7:0]  out_inner_idx, out_outer_idx;
`ifdef LOOP_NEST_CTRL_ABORT_EN
    logic        abort, aborted;
`endif

    int errors = 0;
    int checks = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    loop_nest_ctrl #(.IDX_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_base(cfg_base),
        .cfg_inner_cnt(cfg_inner_cnt), .cfg_outer_cnt(cfg_outer_cnt),
        .cfg_inner_stride(cfg_inner_stride), .cfg_outer_stride(cfg_outer_stride),
        .start(start),
`ifdef LOOP_NEST_CTRL_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_inner_idx(out_inner_idx), .out_outer_idx(out_outer_idx),
        .out_last_inner(out_last_inner), .out_last(out_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] dut_beat();
        return {out_valid, out_addr, out_inner_idx, out_outer_idx, out_last_inner, out_last};
    endfunction

    // Expected beat stream straight from the addressing formula.
    task automatic build_model(input loop_cfg_t c);
        exp_q.delete();
        for (int o = 0; o < int'(c.outer_cnt); o++) begin
            for (int i = 0; i < int'(c.inner_cnt); i++) begin
                logic [15:0] a;
                logic        li, l;
                a  = 16'(c.base + o * c.outer_stride + i * c.inner_stride);
                li = (i == int'(c.inner_cnt) - 1);
                l  = li && (o == int'(c.outer_cnt) - 1);
                exp_q.push_back({1'b1, a, 8'(i), 8'(o), li, l});
            end
        end
    endtask

    task automatic drive_cfg(input loop_cfg_t c);
        cfg_base         = c.base;
        cfg_inner_cnt    = c.inner_cnt;
        cfg_outer_cnt    = c.outer_cnt;
        cfg_inner_stride = c.inner_stride;
        cfg_outer_stride = c.outer_stride;
    endtask

    task automatic garbage_cfg();
        cfg_base         = 16'($urandom);
        cfg_inner_cnt    = 8'($urandom);
        cfg_outer_cnt    = 8'($urandom);
        cfg_inner_stride = 16'($urandom);
        cfg_outer_stride = 16'($urandom);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready
    task automatic run_nest(input loop_cfg_t c, input int mode, input bit sep, input bit disturb);
        int idx, cyc;
        bit rdy;
        build_model(c);
        @(negedge clk);
        chk("cfg_ready_idle", cfg_ready, 1);
        drive_cfg(c);
        cfg_valid = 1'b1;
        start     = !sep;
        if (sep) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            garbage_cfg();
            start = 1'b1;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        if (exp_q.size() == 0) begin
            chk("empty_valid", out_valid, 0);
            chk("empty_done", done, 1);
            chk("empty_busy", busy, 1);
            @(negedge clk);
            chk("empty_done_after", done, 0);
            chk("empty_busy_after", busy, 0);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 4000) begin
            chk("beat", dut_beat(), exp_q[idx]);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            if (disturb) chk("cfg_ready_run", cfg_ready, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (disturb) begin
                garbage_cfg();
                cfg_valid = 1'b1;
                start     = 1'b1;
                if (rdy && idx == exp_q.size() - 1) begin
                    cfg_valid = 1'b0;
                    start     = 1'b0;
                end
            end
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("beats_within_budget", idx, exp_q.size());
        chk("done_pulse", done, 1);
        chk("valid_after_last", out_valid, 0);
        chk("busy_done", busy, 1);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        loop_cfg_t c;
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
`ifdef LOOP_NEST_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        garbage_cfg();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", dut_beat(), 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        c = '{base: 16'h0100, inner_cnt: 8'd3, outer_cnt: 8'd2, inner_stride: 16'd4, outer_stride: 16'h0020};
        run_nest(c, 0, 1'b0, 1'b0);
        run_nest(c, 1, 1'b0, 1'b0);
        run_nest(c, 2, 1'b0, 1'b1);

        c = '{base: 16'h0040, inner_cnt: 8'd0, outer_cnt: 8'd5, inner_stride: 16'd1, outer_stride: 16'd1};
        run_nest(c, 0, 1'b0, 1'b0);
        c = '{base: 16'h0040, inner_cnt: 8'd2, outer_cnt: 8'd0, inner_stride: 16'd1, outer_stride: 16'd1};
        run_nest(c, 0, 1'b1, 1'b0);

        c = '{base: 16'hFFFC, inner_cnt: 8'd3, outer_cnt: 8'd1, inner_stride: 16'd4, outer_stride: 16'h0100};
        run_nest(c, 0, 1'b0, 1'b0);

        c = '{base: 16'h1234, inner_cnt: 8'd255, outer_cnt: 8'd1, inner_stride: 16'd1, outer_stride: 16'd0};
        run_nest(c, 0, 1'b0, 1'b0);

        // reset in the middle of a run
        c = '{base: 16'h0200, inner_cnt: 8'd4, outer_cnt: 8'd3, inner_stride: 16'd8, outer_stride: 16'h0040};
        build_model(c);
        @(negedge clk);
        drive_cfg(c);
        cfg_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("pre_reset_beat", dut_beat(), exp_q[k]);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("midrun_reset_outputs", dut_beat(), 0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_done", done, 0);
        chk("midrun_reset_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_done", done, 0);
        chk("post_reset_valid", out_valid, 0);

        for (int n = 0; n < 8; n++) begin
            c.base         = 16'($urandom);
            c.inner_cnt    = 8'($urandom_range(0, 6));
            c.outer_cnt    = 8'($urandom_range(0, 5));
            c.inner_stride = 16'($urandom);
            c.outer_stride = 16'($urandom);
            run_nest(c, 2, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef LOOP_NEST_CTRL_ABORT_EN
        c = '{base: 16'h0000, inner_cnt: 8'd255, outer_cnt: 8'd1, inner_stride: 16'd1, outer_stride: 16'd0};
        build_model(c);
        @(negedge clk);
        drive_cfg(c);
        cfg_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("abort_beat", dut_beat(), exp_q[k]);
            abort = (k == 9);
            @(negedge clk);
        end
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_flag", aborted, 1);
        @(negedge clk);
        chk("abort_done_clear", done, 0);
        chk("abort_flag_sticky", aborted, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_no_effect", cfg_ready, 1);
        c = '{base: 16'h0010, inner_cnt: 8'd2, outer_cnt: 8'd2, inner_stride: 16'd2, outer_stride: 16'd16};
        run_nest(c, 0, 1'b0, 1'b0);
        chk("abort_flag_cleared", aborted, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
